// File: rtl/inv_share_arbiter.sv
// inv_share_arbiter
//   Round-robin arbiter and sequencer that shares one registered W-bit
//   inverter datapath between N requesters. The winner's operand is latched
//   at grant and held for SETTLE cycles. Its complement is then returned on
//   dout, together with a one-cycle done pulse to that requester.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   req    in   [N]   per-requester level request
//   din    in   [N*W] operands, requester r owns din[r*W +: W]
//   gnt    out  [N]   one-hot grant, registered
//   busy   out  high whenever the sequencer is not idle
//   done   out  [N]   one-hot, one-cycle result-valid pulse
//   dout   out  [W]   result register, holds until the next result
//
// state  | meaning
// IDLE   | waiting for any request, arbitrates from ptr
// SETTLE | operand held; counter runs down to zero
// DONE   | result valid and done pulsing; grant released on exit
module inv_share_arbiter #(
    parameter int N      = 4,
    parameter int W      = 8,
    parameter int SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] din,
    output logic [N-1:0]   gnt,
    output logic           busy,
    output logic [N-1:0]   done,
    output logic [W-1:0]   dout
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_q, win_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  opnd_q, opnd_d;
    logic [W-1:0]  dout_q, dout_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  done_q, done_d;

    logic          found;
    logic [PW-1:0] pick;
    logic [W-1:0]  slice [N];

    for (genvar r = 0; r < N; r++) begin : g_slice
        assign slice[r] = din[r*W +: W];
    end

    // Search ptr, ptr+1, ..., wrapping mod N; the first set request wins.
    always_comb begin : rr_pick
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        dout_d  = dout_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    win_d       = pick;
                    opnd_d      = slice[pick];
                    // The counter holds the remaining settle cycles minus one,
                    // so the result lands exactly SETTLE edges after grant.
                    cnt_d       = CW'(SETTLE - 1);
                    state_d     = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    dout_d  = ~opnd_q;
                    done_d  = gnt_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            opnd_q  <= '0;
            dout_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            dout_q  <= dout_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign dout = dout_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_inv_share_arbiter.sv
module tb_inv_share_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   din;
    logic [N-1:0]     gnt;
    logic [N-1:0]     done;
    logic             busy;
    logic [W-1:0]     dout;

    logic [1:0]       req2;
    logic [7:0]       din2;
    logic [1:0]       gnt2;
    logic [1:0]       done2;
    logic             busy2;
    logic [3:0]       dout2;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    inv_share_arbiter #(.N(4), .W(8), .SETTLE(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    inv_share_arbiter #(.N(2), .W(4), .SETTLE(1)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req2),
        .din   (din2),
        .gnt   (gnt2),
        .busy  (busy2),
        .done  (done2),
        .dout  (dout2)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] din;
        logic [3:0]  gnt;
        logic [3:0]  done;
        logic [7:0]  dout;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] r, input logic [31:0] d,
                       input logic [3:0] g, input logic [3:0] dn,
                       input logic [7:0] o, input logic b);
        vec_t v;
        v.req = r; v.din = d; v.gnt = g; v.done = dn; v.dout = o; v.busy = b;
        tbl.push_back(v);
    endtask

    // Packed as {gnt, done, busy, dout}.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got gnt/done/busy/dout=%h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [3:0] g, input logic [3:0] dn,
                                       input logic b, input logic [7:0] o);
        return {15'd0, g, dn, b, o};
    endfunction

    function automatic logic [31:0] pk2(input logic [1:0] g, input logic [1:0] dn,
                                        input logic b, input logic [3:0] o);
        return {21'd0, g, dn, b, o};
    endfunction

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            req = tbl[i].req;
            din = tbl[i].din;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), pk(gnt, done, busy, dout),
                  pk(tbl[i].gnt, tbl[i].done, tbl[i].busy, tbl[i].dout));
        end
    endtask

    initial begin
        int t1_end, t2_end, t3_end, t4_end;
        logic [7:0] rr_dout [5];
        logic [3:0] oh;
        logic [7:0] prev;
        logic [3:0] exp_dout2;
        logic [1:0] g2;
        rr_dout = '{8'hFF, 8'hF0, 8'h0F, 8'h00, 8'hFF};

        // Test 1: single request after reset.
        add(4'b0001, 32'h000000A5, 4'b0001, 4'b0000, 8'h00, 1'b1);
        add(4'b0001, 32'h000000A5, 4'b0001, 4'b0000, 8'h00, 1'b1);
        add(4'b0001, 32'h000000A5, 4'b0001, 4'b0001, 8'h5A, 1'b1);
        add(4'b0000, 32'h00000000, 4'b0000, 4'b0000, 8'h5A, 1'b0);
        add(4'b0000, 32'h00000000, 4'b0000, 4'b0000, 8'h5A, 1'b0);
        t1_end = tbl.size();

        // Test 2: rotation with all requests held, starting from ptr 0.
        for (int g = 0; g < 5; g++) begin
            oh   = 4'b0001 << (g % 4);
            prev = (g == 0) ? 8'h00 : rr_dout[g-1];
            add(4'b1111, 32'hFFF00F00, oh, 4'b0000, prev, 1'b1);
            add(4'b1111, 32'hFFF00F00, oh, 4'b0000, prev, 1'b1);
            add(4'b1111, 32'hFFF00F00, oh, oh, rr_dout[g], 1'b1);
            add((g == 4) ? 4'b0000 : 4'b1111, 32'hFFF00F00, 4'b0000, 4'b0000, rr_dout[g], 1'b0);
        end
        add(4'b0000, 32'h00000000, 4'b0000, 4'b0000, 8'hFF, 1'b0);
        t2_end = tbl.size();

        // Test 3: operand isolation (ptr 1 -> requester 2 wins).
        add(4'b0100, 32'h003C0000, 4'b0100, 4'b0000, 8'hFF, 1'b1);
        add(4'b0000, 32'h00FF0000, 4'b0100, 4'b0000, 8'hFF, 1'b1);
        add(4'b0000, 32'h00FF0000, 4'b0100, 4'b0100, 8'hC3, 1'b1);
        add(4'b0000, 32'h00FF0000, 4'b0000, 4'b0000, 8'hC3, 1'b0);
        add(4'b0000, 32'h00FF0000, 4'b0000, 4'b0000, 8'hC3, 1'b0);
        add(4'b0000, 32'h00FF0000, 4'b0000, 4'b0000, 8'hC3, 1'b0);
        t3_end = tbl.size();

        // Test 4: requester 1 completes (ptr 2), then req=0011 wraps to 0.
        add(4'b0010, 32'h00001100, 4'b0010, 4'b0000, 8'hC3, 1'b1);
        add(4'b0010, 32'h00001100, 4'b0010, 4'b0000, 8'hC3, 1'b1);
        add(4'b0010, 32'h00001100, 4'b0010, 4'b0010, 8'hEE, 1'b1);
        add(4'b0000, 32'h00000000, 4'b0000, 4'b0000, 8'hEE, 1'b0);
        add(4'b0011, 32'h00001122, 4'b0001, 4'b0000, 8'hEE, 1'b1);
        add(4'b0011, 32'h00001122, 4'b0001, 4'b0000, 8'hEE, 1'b1);
        add(4'b0011, 32'h00001122, 4'b0001, 4'b0001, 8'hDD, 1'b1);
        add(4'b0011, 32'h00001122, 4'b0000, 4'b0000, 8'hDD, 1'b0);
        add(4'b0011, 32'h00001122, 4'b0010, 4'b0000, 8'hDD, 1'b1);
        add(4'b0011, 32'h00001122, 4'b0010, 4'b0000, 8'hDD, 1'b1);
        add(4'b0011, 32'h00001122, 4'b0010, 4'b0010, 8'hEE, 1'b1);
        add(4'b0000, 32'h00000000, 4'b0000, 4'b0000, 8'hEE, 1'b0);
        t4_end = tbl.size();

        rst_n = 1'b1;
        req   = '0;
        din   = '0;
        req2  = '0;
        din2  = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_dut", pk(gnt, done, busy, dout), pk(4'b0, 4'b0, 1'b0, 8'h00));
        check("reset_dut2", pk2(gnt2, done2, busy2, dout2), pk2(2'b0, 2'b0, 1'b0, 4'h0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        apply(0, t1_end);

        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        #1;
        check("reset_between", pk(gnt, done, busy, dout), pk(4'b0, 4'b0, 1'b0, 8'h00));
        @(negedge clk);
        rst_n = 1'b1;

        apply(t1_end, t2_end);
        apply(t2_end, t3_end);
        apply(t3_end, t4_end);

        // Test 5: reset during SETTLE of requester 3 (ptr is 2 here).
        @(negedge clk);
        req = 4'b1000;
        din = 32'h77000000;
        @(posedge clk); #1;
        check("rst_mid_grant", pk(gnt, done, busy, dout), pk(4'b1000, 4'b0, 1'b1, 8'hEE));
        @(posedge clk); #1;
        check("rst_mid_settle", pk(gnt, done, busy, dout), pk(4'b1000, 4'b0, 1'b1, 8'hEE));
        rst_n = 1'b0;
        #1;
        check("rst_mid_async", pk(gnt, done, busy, dout), pk(4'b0, 4'b0, 1'b0, 8'h00));
        req = 4'b1001;
        din = 32'h77000012;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("rst_hold%0d", c), pk(gnt, done, busy, dout), pk(4'b0, 4'b0, 1'b0, 8'h00));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_rel_grant", pk(gnt, done, busy, dout), pk(4'b0001, 4'b0, 1'b1, 8'h00));
        @(posedge clk); #1;
        check("rst_rel_settle", pk(gnt, done, busy, dout), pk(4'b0001, 4'b0, 1'b1, 8'h00));
        @(posedge clk); #1;
        check("rst_rel_done", pk(gnt, done, busy, dout), pk(4'b0001, 4'b0001, 1'b1, 8'hED));
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk); #1;
        check("rst_rel_idle", pk(gnt, done, busy, dout), pk(4'b0, 4'b0, 1'b0, 8'hED));

        // Test 6: N=2, W=4, SETTLE=1 instance, both requests held.
        @(negedge clk);
        req2      = 2'b11;
        din2      = 8'h3A;
        exp_dout2 = 4'h0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            g2 = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
            case (c % 3)
                0: check($sformatf("p6_grant%0d", c), pk2(gnt2, done2, busy2, dout2),
                         pk2(g2, 2'b00, 1'b1, exp_dout2));
                1: begin
                    exp_dout2 = (g2 == 2'b01) ? 4'h5 : 4'hC;
                    check($sformatf("p6_done%0d", c), pk2(gnt2, done2, busy2, dout2),
                          pk2(g2, g2, 1'b1, exp_dout2));
                end
                default: check($sformatf("p6_idle%0d", c), pk2(gnt2, done2, busy2, dout2),
                               pk2(2'b00, 2'b00, 1'b0, exp_dout2));
            endcase
        end
        @(negedge clk);
        req2 = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/inv_share_arbiter.md
# inv_share_arbiter

Round-robin arbiter and sequencer that shares one registered W-bit inverter datapath between N requesters. Each granted requester's operand is latched, held for a fixed settle window that models the inverter's propagation delay, then returned as the bitwise complement with a one-cycle done pulse. It sits between the requesters and the shared inverter datapath, and is the only path to that datapath.

## Interface
- N, 4: number of requesters, 2..8
- W, 8: operand/result width, 1..32
- SETTLE, 2: cycles the operand is held before the result is captured, 1..15

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  per-requester request, level; bit r = requester r
- din  input  N*W  operands; requester r owns bits [r*W +: W]
- gnt  output  N  one-hot grant, registered
- busy  output  1  high when state is not IDLE
- done  output  N  one-hot, one-cycle result-valid pulse to the granted requester
- dout  output  W  result register, ~operand; holds its value until the next DONE

## Operation
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - gnt = 0, done = 0, dout = 0, busy = 0.
  - State = IDLE; priority pointer ptr = 0; settle counter = 0; operand register = 0.
- State IDLE:
  - If req != 0, select the first set bit searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
  - Set gnt to the one-hot of the winner.
  - Latch operand = din slice of the winner.
  - Load counter = SETTLE-1; go to SETTLE.
  - If req == 0, stay in IDLE.
- State SETTLE:
  - gnt held.
  - If counter == 0: dout <= ~operand, done <= gnt, go to DONE.
  - Else decrement the counter.
- State DONE:
  - done is high for exactly this cycle.
  - gnt <= 0; ptr <= (winner+1) mod N; go to IDLE.
- Operand is captured only at grant. Later changes to din or req have no effect on the operation in flight.
- Dropping req during SETTLE or DONE: the operation still completes, and done still pulses for that requester.
- Requesters are expected to hold req until their done. A req still high after done re-enters arbitration at the rotated priority.
- At most one operation is in flight at a time. There is no queueing, and requests are never lost while held.
- Only one bit of gnt and one bit of done is ever set, and each matches the winner.

## Timing
- Edge k, in IDLE with req != 0: gnt and busy go high after edge k.
- Edge k+SETTLE: dout updates and done goes high.
- Edge k+SETTLE+1: done, gnt and busy go low; state returns to IDLE.
- Earliest next grant: edge k+SETTLE+2.
- Throughput: one operation per SETTLE+2 cycles.
- done and the new dout are visible in the same cycle. gnt is still high during the done cycle.
- Fairness: with all N requests held continuously, each requester is granted once per N operations.
- A new request arriving in the same cycle as the DONE edge is seen on the following IDLE edge.
- Reset asserted mid-operation:
  - All outputs clear immediately, asynchronously.
  - The in-flight operation is discarded and no done is produced.
  - After release, ptr = 0 and arbitration restarts from requester 0.
- dout is not cleared on DONE exit. It changes only at a DONE entry or on reset.

## Test plan
1. Reset then single request:
   - Stimulus: rst_n low then released; req=0001, din slice0=8'hA5, asserted before edge k.
   - Required response: gnt=0001 after edge k; done=0001 and dout=8'h5A after edge k+2; gnt=0 and busy=0 after edge k+3.
2. Round-robin rotation:
   - Stimulus: req=1111 held; slices 8'h00, 8'h0F, 8'hF0, 8'hFF.
   - Required response: grants 0001, 0010, 0100, 1000, then 0001 again; dout sequence FF, F0, 0F, 00; successive grants 4 cycles apart.
3. Operand isolation:
   - Stimulus: req=0100 with slice2=8'h3C; after the grant, change slice2 to 8'hFF and drop req.
   - Required response: done=0100 and dout=8'hC3 at edge k+2; no further grant.
4. Pointer skip:
   - Stimulus: after requester 1 completes (ptr=2), raise req=0011.
   - Required response: next grant is 0001 (wrap-around from ptr 2 past empty 2 and 3), not 0010.
5. Reset mid-operation:
   - Stimulus: assert rst_n low at k+1 during SETTLE of requester 3.
   - Required response: gnt, done and busy go to 0 without waiting for a clock edge; dout=0; no done pulse afterwards; after release with req=1001, the grant is 0001.
6. Parameter variant:
   - Stimulus: SETTLE=1, W=4, N=2; req=11 held.
   - Required response: grants alternate 01, 10 every 3 cycles; done one cycle wide; dout = ~din slice, 4 bits.
